// File: rtl/video_pkg.sv
// Shared video-subsystem definitions: framebuffer geometry and the response-slot record.
package video_pkg;

    localparam int FB_DATA_WIDTH = 128;
    localparam int FB_ADDR_WIDTH = 12;

    typedef struct packed {
        logic valid;
        logic err;
    } fb_resp_slot_t;

endpackage

// File: rtl/fb_bram.sv
// Single-port framebuffer RAM with byte-enable writes and a registered 1-cycle read.
module fb_bram #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                    clk_i,
    input  logic                    i_en,
    input  logic                    i_we,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    input  logic [DATA_WIDTH/8-1:0] i_sel,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    output logic [DATA_WIDTH-1:0]   o_rdata
);

    localparam int NBYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk_i) begin
        if (i_en) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (i_we && i_sel[b]) begin
                    r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/video_fb_responder.sv
// Pipelined Wishbone slave for the framebuffer RAM: in-order ack/err after a fixed
// RD_LAT (1 or 2), byte-masked writes, out-of-range detection, cyc-drop flush.
module video_fb_responder
    import video_pkg::*;
#(
    parameter int DATA_WIDTH = FB_DATA_WIDTH,
    parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
    parameter int RD_LAT     = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_we_i,
    input  logic [31:0]             wb_addr_i,
    input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
    input  logic [DATA_WIDTH-1:0]   wb_wdata_i,
    output logic                    wb_stall_o,
    output logic                    wb_ack_o,
    output logic                    wb_err_o,
    output logic [DATA_WIDTH-1:0]   wb_rdata_o,
    input  logic                    hold_i,
    output logic                    busy_o
);

    logic                  w_in_range;
    logic                  w_accept;
    logic                  w_ram_en;
    logic                  w_ram_we;
    logic [DATA_WIDTH-1:0] w_ram_rdata;
    logic [DATA_WIDTH-1:0] w_stage0_data;
    logic [DATA_WIDTH-1:0] w_out_data;
    logic                  w_live;
    fb_resp_slot_t         w_last;

    fb_resp_slot_t r_slot [RD_LAT];
    logic          r_rd;

    assign wb_stall_o = hold_i | rst_i;
    assign w_in_range = (wb_addr_i[31:ADDR_WIDTH] == '0);
    assign w_accept   = wb_cyc_i & wb_stb_i & ~wb_stall_o;
    assign w_ram_en   = w_accept & w_in_range;
    assign w_ram_we   = w_ram_en & wb_we_i;

    fb_bram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bram (
        .clk_i   (clk_i),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (wb_addr_i[ADDR_WIDTH-1:0]),
        .i_sel   (wb_sel_i),
        .i_wdata (wb_wdata_i),
        .o_rdata (w_ram_rdata)
    );

    // Dropping cyc (or reset) abandons everything in flight; committed writes stay.
    always_ff @(posedge clk_i) begin
        if (rst_i || !wb_cyc_i) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_slot[i] <= '0;
            end
            r_rd <= 1'b0;
        end else begin
            r_slot[0].valid <= w_accept;
            r_slot[0].err   <= w_accept & ~w_in_range;
            r_rd            <= w_accept & w_in_range & ~wb_we_i;
            for (int i = 1; i < RD_LAT; i++) begin
                r_slot[i] <= r_slot[i-1];
            end
        end
    end

    assign w_stage0_data = r_rd ? w_ram_rdata : '0;

    generate
        if (RD_LAT == 2) begin : g_out_reg
            logic [DATA_WIDTH-1:0] r_rdata_q;
            always_ff @(posedge clk_i) begin
                if (rst_i || !wb_cyc_i) begin
                    r_rdata_q <= '0;
                end else begin
                    r_rdata_q <= w_stage0_data;
                end
            end
            assign w_out_data = r_rdata_q;
        end else begin : g_no_out_reg
            assign w_out_data = w_stage0_data;
        end
    endgenerate

    // Responses are masked while cyc is low or in reset so nothing leaks out of a flush.
    assign w_live     = wb_cyc_i & ~rst_i;
    assign w_last     = r_slot[RD_LAT-1];
    assign wb_ack_o   = w_live & w_last.valid & ~w_last.err;
    assign wb_err_o   = w_live & w_last.valid & w_last.err;
    assign wb_rdata_o = wb_ack_o ? w_out_data : '0;

    always_comb begin
        busy_o = 1'b0;
        for (int i = 0; i < RD_LAT; i++) begin
            busy_o = busy_o | r_slot[i].valid;
        end
    end

endmodule
